des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
Iterative DES key schedule that feeds the S-box stage. It generates the sixteen 48-bit round subkeys, one per accepted handshake. The round datapath XORs each subkey with E(R) to form the 6-bit S-box inputs. It supports encrypt order (K1..K16) and decrypt order (K16..K1) from a single 64-bit key load.

Parameters:
AUTO_ADVANCE, 0, when 1 subkey_ready is ignored and the schedule advances every cycle while busy

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
key_in  input  64  [1:64] DES key, MSB-first; parity bits 8,16,...,64 ignored
decrypt  input  1  sampled with start; 1 = emit K16 first
start  input  1  single-cycle load request; honoured only in IDLE
subkey_ready  input  1  round datapath has consumed the current subkey
subkey  output  48  [1:48] current round subkey, PC2(C,D)
round_no  output  4  0..15, index of the emitted step (0 = first subkey emitted)
subkey_valid  output  1  subkey/round_no valid
busy  output  1  high in ROUND state
done  output  1  one-cycle pulse after final subkey accepted

Behaviour:
- Clock is one domain (clk). Reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE; C,D (28b each)=0; round_no=0.
  - subkey_valid=0, busy=0, done=0.
  - subkey=PC2(0)=0.
- States: IDLE, ROUND.
- IDLE with start=1:
  - Latch dir=decrypt.
  - {C,D} <= PC1(key_in) rotated by the first step shift: encrypt left 1, decrypt 0.
  - round_no <= 0; go to ROUND.
  - subkey_valid rises the cycle after start (latency 1).
- ROUND:
  - subkey_valid=1, busy=1; subkey is a combinational PC2 of the registered C,D.
  - Accept = subkey_valid & (subkey_ready | AUTO_ADVANCE).
  - On accept with round_no<15: round_no+1; C,D rotate by the next step shift.
  - On accept with round_no=15: go to IDLE; done=1 for one cycle; subkey_valid=0.
  - Without accept: hold all state; subkey stable (stall).
- Encrypt left-shift per round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
- Decrypt right-shift applied entering step j=1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Step j emits K(17-j).
- Rotations operate independently on 28-bit C and D; wrap-around is circular.
- start while busy: ignored; the current schedule continues unchanged and dir is not re-sampled.
- start in the same cycle as the final accept: ignored (state is ROUND that cycle). A new start is accepted in the next IDLE cycle.
- decrypt changing mid-schedule: no effect.
- rst asserted mid-schedule: immediate return to reset values; no done pulse.
- key_in parity bits never influence subkey.

Decomposition:
- des_pkg holds the shared constants:
  - PC1 table (56 entries) and PC2 table (48 entries), 1-based indices.
  - Encrypt shift schedule (16 x 2b) and decrypt shift schedule.
  - state_t enum {IDLE, ROUND}.
- One sub-module: des_pc2, a combinational 56->48 permutation instanced on {C,D}.
- PC1 and the rotations stay inline.

Test Plan:
- Encrypt: key_in=0x133457799BBCDFF1, decrypt=0, start pulse, subkey_ready=1 -> cycle+1 subkey=0x1B02EFFC7072 (round_no 0), next 0x79AED9DBC9E5, round_no 15 subkey=0xCB3D8B0E17F5; done pulses exactly once, 16 cycles after first valid.
- Decrypt: same key, decrypt=1 -> first subkey=0xCB3D8B0E17F5, second equals encrypt round_no 14 value, last=0x1B02EFFC7072; emitted sequence is the exact reverse of the encrypt run.
- Stall: encrypt, hold subkey_ready=0 for 5 cycles at round_no 1 -> subkey stays 0x79AED9DBC9E5, round_no stays 1, no done; resumes correctly on ready.
- Parity/start-while-busy: key 0x133457799BBCDFF1 with all parity bits flipped -> identical subkeys. Pulse start with a different key at round_no 7 -> ignored; sequence unchanged.
- Reset mid-run: assert rst at round_no 9 -> same cycle subkey_valid=0, busy=0, subkey=0, done never pulses; a fresh start after release gives K1=0x1B02EFFC7072.
- AUTO_ADVANCE=1: subkey_ready tied 0 -> 16 consecutive valid cycles, then done; total start-to-done = 17 cycles.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC1/PC2 tables (1-based, bit 1 = MSB),
// per-step rotation amounts, FSM state type and small permutation/rotate helpers.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left shift applied for encrypt step n; right shift applied entering decrypt step n.
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // DES bit b (1 = MSB) of the 64-bit key sits at key[64-b]; parity bits are never selected.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC2 compression of the 56-bit {C,D} register into a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) subkey_o[47-i] = cd_i[56-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit subkey per accepted handshake, encrypt
// (K1..K16) or decrypt (K16..K1) order from a single key load; done pulses after K-last.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit AUTO_ADVANCE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_no,
  output logic        subkey_valid,
  output logic        busy,
  output logic        done
);

  state_t      state_q;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [3:0]  round_q;
  logic [3:0]  step_nxt;
  logic        dir_q;
  logic        done_q;
  logic        accept;
  logic [55:0] cd_pc1;

  assign cd_pc1       = pc1(key_in);
  assign step_nxt     = round_q + 4'd1;
  assign subkey_valid = (state_q == ROUND);
  assign busy         = (state_q == ROUND);
  assign accept       = subkey_valid & (subkey_ready | AUTO_ADVANCE);
  assign round_no     = round_q;
  assign done         = done_q;

  // In IDLE this is the load value; in ROUND it is the rotation into the next step.
  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (state_q == IDLE) begin
      if (decrypt) begin
        c_d = cd_pc1[55:28];
        d_d = cd_pc1[27:0];
      end else begin
        c_d = rotl28(cd_pc1[55:28], ENC_SHIFT[0]);
        d_d = rotl28(cd_pc1[27:0],  ENC_SHIFT[0]);
      end
    end else if (dir_q) begin
      c_d = rotr28(c_q, DEC_SHIFT[step_nxt]);
      d_d = rotr28(d_q, DEC_SHIFT[step_nxt]);
    end else begin
      c_d = rotl28(c_q, ENC_SHIFT[step_nxt]);
      d_d = rotl28(d_q, ENC_SHIFT[step_nxt]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_q   <= decrypt;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= 4'd0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (accept) begin
            if (round_q == 4'd15) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              round_q <= step_nxt;
              c_q     <= c_d;
              d_q     <= d_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

endmodule
